// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the program-control unit: default widths and FSM state encoding.
package pc_ctrl_pkg;

   localparam int unsigned PC_W_DEF   = 10;
   localparam int unsigned LUT_AW_DEF = 4;

   typedef enum logic [1:0] {
      PC_IDLE = 2'd0,
      PC_RUN  = 2'd1,
      PC_DONE = 2'd2
   } pc_state_e;

endpackage : pc_ctrl_pkg

// File: rtl/pc_ctrl_if.sv
// Bus between the core datapath (master) and the program-control unit (slave).
interface pc_ctrl_if
   import pc_ctrl_pkg::*;
#(
   parameter int unsigned PC_W   = PC_W_DEF,
   parameter int unsigned LUT_AW = LUT_AW_DEF
);

   logic              START;
   logic [PC_W-1:0]   START_ADDR;
   logic              STALL;
   logic              HALT_REQ;
   logic              STATUS_WE;
   logic              ALU_FLAG;
   logic              ALU_OVERFLOW;
   logic              BRANCH_EN;
   logic [LUT_AW-1:0] BR_IDX;
   logic              LUT_WE;
   logic [LUT_AW-1:0] LUT_WADDR;
   logic [PC_W-1:0]   LUT_WDATA;
   logic [PC_W-1:0]   PC;
   logic              FLAG;
   logic              OVERFLOW;
   logic              RUNNING;
   logic              DONE;

   modport master (
      output START, START_ADDR, STALL, HALT_REQ, STATUS_WE, ALU_FLAG, ALU_OVERFLOW,
             BRANCH_EN, BR_IDX, LUT_WE, LUT_WADDR, LUT_WDATA,
      input  PC, FLAG, OVERFLOW, RUNNING, DONE
   );

   modport slave (
      input  START, START_ADDR, STALL, HALT_REQ, STATUS_WE, ALU_FLAG, ALU_OVERFLOW,
             BRANCH_EN, BR_IDX, LUT_WE, LUT_WADDR, LUT_WDATA,
      output PC, FLAG, OVERFLOW, RUNNING, DONE
   );

endinterface : pc_ctrl_if

// File: rtl/pc_ctrl_branch_lut.sv
// Branch-target register file: one synchronous write port, one combinational read port, async clear.
module pc_ctrl_branch_lut
   import pc_ctrl_pkg::*;
#(
   parameter int unsigned PC_W   = PC_W_DEF,
   parameter int unsigned LUT_AW = LUT_AW_DEF
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              we,
   input  logic [LUT_AW-1:0] waddr,
   input  logic [PC_W-1:0]   wdata,
   input  logic [LUT_AW-1:0] raddr,
   output logic [PC_W-1:0]   rdata_c
);

   localparam int unsigned DEPTH = 1 << LUT_AW;

   logic [PC_W-1:0] mem_q [DEPTH];

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Read returns the pre-write entry on a same-cycle write to the same index.
   assign rdata_c = mem_q[raddr];

endmodule : pc_ctrl_branch_lut

// File: rtl/pc_ctrl.sv
// Program-control unit: start/halt FSM, program counter with LUT-resolved branches,
// and the registered ALU flag/overflow fed back to the ALU.
module pc_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter int unsigned PC_W   = PC_W_DEF,
   parameter int unsigned LUT_AW = LUT_AW_DEF
) (
   input logic       CLK,
   input logic       RESET_N,
   pc_ctrl_if.slave  bus
);

   localparam logic [1:0] S_IDLE = 2'(PC_IDLE);
   localparam logic [1:0] S_RUN  = 2'(PC_RUN);
   localparam logic [1:0] S_DONE = 2'(PC_DONE);

   logic [1:0]      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            flag_q, flag_d;
   logic            ovf_q, ovf_d;
   logic            running_q, done_q;
   logic [PC_W-1:0] lut_rdata_c;

   pc_ctrl_branch_lut #(
      .PC_W   (PC_W),
      .LUT_AW (LUT_AW)
   ) u_branch_lut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .we      (bus.LUT_WE),
      .waddr   (bus.LUT_WADDR),
      .wdata   (bus.LUT_WDATA),
      .raddr   (bus.BR_IDX),
      .rdata_c (lut_rdata_c)
   );

   // State and run registers; RUNNING/DONE follow the next state so they switch with it.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         flag_q    <= 1'b0;
         ovf_q     <= 1'b0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         flag_q    <= flag_d;
         ovf_q     <= ovf_d;
         running_q <= (state_d == S_RUN);
         done_q    <= (state_d == S_DONE);
      end
   end

   // Next-state: STALL > HALT_REQ > BRANCH_EN > increment; status commit is independent of halt/branch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      flag_d  = flag_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.START) begin
               state_d = S_RUN;
               pc_d    = bus.START_ADDR;
               flag_d  = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         S_RUN: begin
            if (!bus.STALL) begin
               if (bus.STATUS_WE) begin
                  flag_d = bus.ALU_FLAG;
                  ovf_d  = bus.ALU_OVERFLOW;
               end
               if (bus.HALT_REQ) begin
                  state_d = S_DONE;
               end else if (bus.BRANCH_EN) begin
                  pc_d = lut_rdata_c;
               end else begin
                  pc_d = pc_q + PC_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.PC       = pc_q;
   assign bus.FLAG     = flag_q;
   assign bus.OVERFLOW = ovf_q;
   assign bus.RUNNING  = running_q;
   assign bus.DONE     = done_q;

endmodule : pc_ctrl

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl with hand-computed expected values.
module tb_pc_ctrl;

   localparam int unsigned PC_W   = 10;
   localparam int unsigned LUT_AW = 4;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   pc_ctrl_if #(.PC_W(PC_W), .LUT_AW(LUT_AW)) bus ();

   pc_ctrl #(.PC_W(PC_W), .LUT_AW(LUT_AW)) dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.START        = 1'b0;
      bus.START_ADDR   = '0;
      bus.STALL        = 1'b0;
      bus.HALT_REQ     = 1'b0;
      bus.STATUS_WE    = 1'b0;
      bus.ALU_FLAG     = 1'b0;
      bus.ALU_OVERFLOW = 1'b0;
      bus.BRANCH_EN    = 1'b0;
      bus.BR_IDX       = '0;
      bus.LUT_WE       = 1'b0;
      bus.LUT_WADDR    = '0;
      bus.LUT_WDATA    = '0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      idle_inputs();

      // Reset state
      tick();
      tick();
      chk("rst_pc",       32'(bus.PC), 32'h000);
      chk("rst_flag",     32'(bus.FLAG), 32'd0);
      chk("rst_ovf",      32'(bus.OVERFLOW), 32'd0);
      chk("rst_running",  32'(bus.RUNNING), 32'd0);
      chk("rst_done",     32'(bus.DONE), 32'd0);
      #3 rst_n = 1'b1;
      tick();

      // Load LUT[3] in IDLE
      bus.LUT_WE = 1'b1; bus.LUT_WADDR = 4'd3; bus.LUT_WDATA = 10'h120;
      tick();
      bus.LUT_WE = 1'b0;
      chk("idle_pc", 32'(bus.PC), 32'h000);

      // Sequential fetch and wrap
      bus.START = 1'b1; bus.START_ADDR = 10'h3FE;
      tick();
      bus.START = 1'b0;
      chk("start_pc",      32'(bus.PC), 32'h3FE);
      chk("start_running", 32'(bus.RUNNING), 32'd1);
      tick();
      chk("seq_3ff", 32'(bus.PC), 32'h3FF);
      tick();
      chk("seq_wrap", 32'(bus.PC), 32'h000);
      tick();
      chk("seq_001", 32'(bus.PC), 32'h001);

      // Branch, then same-cycle write/branch uses the old entry
      bus.BRANCH_EN = 1'b1; bus.BR_IDX = 4'd3;
      tick();
      chk("br_120", 32'(bus.PC), 32'h120);
      bus.LUT_WE = 1'b1; bus.LUT_WADDR = 4'd3; bus.LUT_WDATA = 10'h200;
      tick();
      bus.LUT_WE = 1'b0;
      chk("br_old_entry", 32'(bus.PC), 32'h120);
      tick();
      bus.BRANCH_EN = 1'b0;
      chk("br_new_entry", 32'(bus.PC), 32'h200);

      // Status commit and hold
      bus.STATUS_WE = 1'b1; bus.ALU_FLAG = 1'b1; bus.ALU_OVERFLOW = 1'b1;
      tick();
      chk("commit_flag", 32'(bus.FLAG), 32'd1);
      chk("commit_ovf",  32'(bus.OVERFLOW), 32'd1);
      chk("commit_pc",   32'(bus.PC), 32'h201);
      bus.STATUS_WE = 1'b0; bus.ALU_FLAG = 1'b0; bus.ALU_OVERFLOW = 1'b0;
      tick();
      chk("hold_flag", 32'(bus.FLAG), 32'd1);
      chk("hold_ovf",  32'(bus.OVERFLOW), 32'd1);
      chk("hold_pc",   32'(bus.PC), 32'h202);
      bus.STATUS_WE = 1'b1;
      tick();
      bus.STATUS_WE = 1'b0;
      chk("clear_flag", 32'(bus.FLAG), 32'd0);
      chk("clear_pc",   32'(bus.PC), 32'h203);

      // Stall outranks halt, branch and commit
      bus.STALL = 1'b1; bus.HALT_REQ = 1'b1; bus.BRANCH_EN = 1'b1; bus.BR_IDX = 4'd3;
      bus.STATUS_WE = 1'b1; bus.ALU_FLAG = 1'b1; bus.ALU_OVERFLOW = 1'b1;
      tick();
      chk("stall_pc",      32'(bus.PC), 32'h203);
      chk("stall_flag",    32'(bus.FLAG), 32'd0);
      chk("stall_ovf",     32'(bus.OVERFLOW), 32'd0);
      chk("stall_running", 32'(bus.RUNNING), 32'd1);
      chk("stall_done",    32'(bus.DONE), 32'd0);
      idle_inputs();
      tick();
      chk("unstall_pc",      32'(bus.PC), 32'h204);
      chk("unstall_running", 32'(bus.RUNNING), 32'd1);

      // Reset mid-run clears outputs and LUT without a clock edge
      bus.STATUS_WE = 1'b1; bus.ALU_FLAG = 1'b1; bus.ALU_OVERFLOW = 1'b1;
      tick();
      idle_inputs();
      chk("pre_rst_flag", 32'(bus.FLAG), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_pc",      32'(bus.PC), 32'h000);
      chk("arst_flag",    32'(bus.FLAG), 32'd0);
      chk("arst_ovf",     32'(bus.OVERFLOW), 32'd0);
      chk("arst_running", 32'(bus.RUNNING), 32'd0);
      #2 rst_n = 1'b1;
      bus.START = 1'b1; bus.START_ADDR = 10'h010;
      tick();
      bus.START = 1'b0;
      chk("restart_pc",      32'(bus.PC), 32'h010);
      chk("restart_running", 32'(bus.RUNNING), 32'd1);
      bus.BRANCH_EN = 1'b1; bus.BR_IDX = 4'd3;
      tick();
      bus.BRANCH_EN = 1'b0;
      chk("lut_cleared", 32'(bus.PC), 32'h000);

      // Halt at 0x040 with commit; halt outranks branch
      bus.LUT_WE = 1'b1; bus.LUT_WADDR = 4'd4; bus.LUT_WDATA = 10'h040;
      tick();
      bus.LUT_WE = 1'b0;
      chk("run_write_pc", 32'(bus.PC), 32'h001);
      bus.BRANCH_EN = 1'b1; bus.BR_IDX = 4'd4;
      tick();
      chk("br_040", 32'(bus.PC), 32'h040);
      bus.BR_IDX = 4'd3; bus.HALT_REQ = 1'b1;
      bus.STATUS_WE = 1'b1; bus.ALU_FLAG = 1'b1; bus.ALU_OVERFLOW = 1'b0;
      tick();
      idle_inputs();
      chk("halt_done",    32'(bus.DONE), 32'd1);
      chk("halt_running", 32'(bus.RUNNING), 32'd0);
      chk("halt_pc",      32'(bus.PC), 32'h040);
      chk("halt_flag",    32'(bus.FLAG), 32'd1);
      chk("halt_ovf",     32'(bus.OVERFLOW), 32'd0);
      tick();
      chk("done_hold_pc", 32'(bus.PC), 32'h040);
      chk("done_hold",    32'(bus.DONE), 32'd1);

      // Restart from DONE, then START in RUN is ignored
      bus.START = 1'b1; bus.START_ADDR = 10'h000;
      tick();
      chk("rs_running", 32'(bus.RUNNING), 32'd1);
      chk("rs_done",    32'(bus.DONE), 32'd0);
      chk("rs_flag",    32'(bus.FLAG), 32'd0);
      chk("rs_pc",      32'(bus.PC), 32'h000);
      bus.START_ADDR = 10'h155;
      tick();
      bus.START = 1'b0;
      chk("start_in_run_pc",      32'(bus.PC), 32'h001);
      chk("start_in_run_running", 32'(bus.RUNNING), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_pc_ctrl

// File: doc/pc_ctrl.md
# pc_ctrl

Program-control unit that sits on the result side of the ALU in the single-cycle 8-bit core. It registers the ALU's flag and overflow results and feeds them back to the ALU as flag-in and overflow-in. It also consumes the ALU's branch-enable decision to steer the program counter, resolving branch targets through a loadable branch-target lookup table. A small start/halt state machine brackets each program run.

## Interface
Parameters:
- PC_W, 10, program-counter width; PC wraps modulo 2^PC_W
- LUT_AW, 4, branch-target LUT address width (2^LUT_AW entries of PC_W bits)

Ports:
- CLK  in  1  sole clock; all state updates on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- START  in  1  begin a run at START_ADDR (honoured in IDLE or DONE only)
- START_ADDR  in  PC_W  first instruction address of the run
- STALL  in  1  hold all run state this cycle (instruction memory wait)
- HALT_REQ  in  1  current instruction is halt
- STATUS_WE  in  1  commit ALU flag/overflow results this cycle
- ALU_FLAG  in  1  ALU flag result
- ALU_OVERFLOW  in  1  ALU carry/shift-out result
- BRANCH_EN  in  1  ALU branch-taken decision
- BR_IDX  in  LUT_AW  LUT index from the instruction's branch field
- LUT_WE  in  1  LUT write strobe
- LUT_WADDR  in  LUT_AW  LUT write address
- LUT_WDATA  in  PC_W  LUT write data
- PC  out  PC_W  current instruction address
- FLAG  out  1  registered flag, drives ALU flag-in
- OVERFLOW  out  1  registered overflow, drives ALU overflow-in
- RUNNING  out  1  high in RUN
- DONE  out  1  high in DONE

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE.
- Reset values: PC=0, FLAG=0, OVERFLOW=0, RUNNING=0, DONE=0, all LUT entries 0. Reset mid-run aborts immediately to IDLE with these values.
- IDLE or DONE with START=1: next state is RUN, PC<=START_ADDR, FLAG<=0, OVERFLOW<=0, DONE drops.
- RUN priority per cycle, highest first:
  - STALL=1: PC, FLAG, OVERFLOW and state all hold. HALT_REQ, BRANCH_EN and STATUS_WE are ignored.
  - HALT_REQ=1: next state is DONE and PC holds. The status commit below still applies this cycle.
  - BRANCH_EN=1: PC<=LUT[BR_IDX].
  - Otherwise: PC<=PC+1, with 2^PC_W−1 wrapping to 0.
- Status commit: in RUN with STALL=0 and STATUS_WE=1, FLAG<=ALU_FLAG and OVERFLOW<=ALU_OVERFLOW. Otherwise both hold. Commit occurs on branch and halt cycles too.
- START in RUN is ignored.
- DONE holds PC, FLAG and OVERFLOW until the next START.
- LUT writes:
  - Accepted in every state, including during STALL.
  - Write is synchronous; read is combinational.
  - A same-cycle write and branch to the same index uses the old entry.
- PC arithmetic is unsigned PC_W-bit with no carry out. LUT entries are full-width absolute targets.

## Timing
- Branch/increment latency is 1 cycle: the decision sampled at edge N appears on PC after edge N.
- FLAG/OVERFLOW reach the ALU one cycle after commit. A compare followed by a branch in the next instruction sees the new flag.
- RUNNING/DONE are registered and change on the same edge as the state transition.
- RESET_N assertion clears outputs without waiting for a clock. Deassertion is synchronised externally.

## Structure
- Shared definitions package holds:
  - pc_state_e enum {IDLE, RUN, DONE}, used for waveform viewing
  - PC_W and LUT_AW defaults
- Sub-module branch_lut: 2^LUT_AW×PC_W register file with one synchronous write port, one combinational read port and async clear.
- pc_ctrl holds the FSM, PC register and status register.

## Test plan
- Reset mid-run: PC=0x05 in RUN, pulse RESET_N low -> PC=0, FLAG=0, OVERFLOW=0, RUNNING=0 immediately. START with START_ADDR=0x010 -> PC=0x010, RUNNING=1 next cycle.
- Sequential fetch and wrap: START at 0x3FE, three free cycles -> PC goes 0x3FE, 0x3FF, 0x000, 0x001.
- Branch:
  - Load LUT[3]=0x120, then BRANCH_EN=1 with BR_IDX=3 -> PC=0x120.
  - Same cycle as another branch to index 3, write LUT[3]=0x200 -> PC=0x120; a later branch to index 3 gives 0x200.
- Stall priority: STALL=1 with BRANCH_EN=1, HALT_REQ=1 and STATUS_WE=1 (ALU_FLAG=1) -> PC, FLAG and state unchanged. Release STALL -> normal behaviour resumes.
- Status commit: STATUS_WE=1 with ALU_FLAG=1, ALU_OVERFLOW=1 -> FLAG=1, OVERFLOW=1 next cycle. STATUS_WE=0 with inputs 0 -> both hold at 1.
- Halt and restart: HALT_REQ at PC=0x040 with STATUS_WE=1, ALU_FLAG=1 -> DONE=1, PC=0x040, FLAG=1. START at 0x000 -> RUN, FLAG=0. START while RUN -> ignored.
